// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage_if
// Description : Valid/ready operation and result bus for the ALU execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation_code;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic        set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        illegal_op;
    logic [3:0]  nzcv;

    modport master (
        output in_valid, operation_code, operand_a, operand_b, set_flags, out_ready,
        input  in_ready, out_valid, result, zero, illegal_op, nzcv
    );

    modport slave (
        input  in_valid, operation_code, operand_a, operand_b, set_flags, out_ready,
        output in_ready, out_valid, result, zero, illegal_op, nzcv
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Single-register ALU execute stage with valid/ready handshake
//               and an architectural NZCV flag register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_exec_stage_if.slave  bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic        out_valid_q;
    logic [63:0] result_q;
    logic        zero_q;
    logic        illegal_q;
    logic [3:0]  nzcv_q;

    logic [63:0] result_d;
    logic        carry_d;
    logic        ovf_d;
    logic        legal_d;
    logic [64:0] add_sum;
    logic [64:0] sub_sum;
    logic        accept;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Subtraction is a + ~b + 1 so the carry out reads as "no borrow".
    assign add_sum = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    assign sub_sum = {1'b0, bus.operand_a} + {1'b0, ~bus.operand_b} + 65'd1;

    always_comb begin
        result_d = 64'd0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        legal_d  = 1'b1;
        case (bus.operation_code)
            OP_AND:  result_d = bus.operand_a & bus.operand_b;
            OP_ORR:  result_d = bus.operand_a | bus.operand_b;
            OP_NOR:  result_d = ~(bus.operand_a | bus.operand_b);
            OP_PASS: result_d = bus.operand_b;
            OP_ADD: begin
                result_d = add_sum[63:0];
                carry_d  = add_sum[64];
                ovf_d    = (bus.operand_a[63] == bus.operand_b[63]) &&
                           (add_sum[63] != bus.operand_a[63]);
            end
            OP_SUB: begin
                result_d = sub_sum[63:0];
                carry_d  = sub_sum[64];
                ovf_d    = (bus.operand_a[63] != bus.operand_b[63]) &&
                           (sub_sum[63] != bus.operand_a[63]);
            end
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= 64'd0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            nzcv_q      <= 4'b0000;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            zero_q      <= (result_d == 64'd0);
            illegal_q   <= !legal_d;
            if (bus.set_flags && legal_d) begin
                nzcv_q <= {result_d[63], (result_d == 64'd0), carry_d, ovf_d};
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.illegal_op = illegal_q;
    assign bus.nzcv       = nzcv_q;

endmodule
`default_nettype wire
